// File: rtl/bnn_pkg.sv
// Shared BNN types and width helpers.
// Used by the XNOR/popcount engine and the layer controller.
package bnn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/xnor_popcount_chunk.sv
// Combinational XNOR + popcount of one CHUNK-bit slice.
// Agreement count between weights and activations.
module xnor_popcount_chunk
    import bnn_pkg::*;
#(
    parameter  int CHUNK = 64,
    localparam int CW    = cnt_w(CHUNK)
) (
    input  logic [CHUNK-1:0] w,
    input  logic [CHUNK-1:0] a,
    output logic [CW-1:0]    cnt
);

    logic [CHUNK-1:0] x;

    assign x = w ~^ a;

    // Count agreeing bit positions.
    always_comb begin
        cnt = '0;
        for (int i = 0; i < CHUNK; i++) begin
            cnt = cnt + CW'(x[i]);
        end
    end

endmodule

// File: rtl/xnor_popcount_seq.sv
// Sequential BNN neuron engine: chunked XNOR-popcount + sign.
// Define XNOR_BIAS_EN for a per-row threshold input (thr_in).
module xnor_popcount_seq
    import bnn_pkg::*;
#(
    parameter  int WIDTH   = 512,
    parameter  int CHUNK   = 64,
    parameter  int NEURONS = 16,
    localparam int CNT_W   = cnt_w(WIDTH),
    localparam int IDX_W   = idx_w(NEURONS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   act_in,
    output logic               busy,
    input  logic               w_valid,
    output logic               w_ready,
    input  logic [CHUNK-1:0]   w_data,
`ifdef XNOR_BIAS_EN
    input  logic [CNT_W-1:0]   thr_in,
`endif
    output logic               bit_valid,
    output logic               bit_out,
    output logic [IDX_W-1:0]   bit_idx,
    output logic [NEURONS-1:0] result,
    output logic               done
);

    localparam int BEATS = WIDTH / CHUNK;
    localparam int BW    = idx_w(BEATS);
    localparam int CW    = cnt_w(CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_cfg
        $error("WIDTH must be a multiple of CHUNK");
    end

    state_t             state;
    state_t             state_nx;
    logic [WIDTH-1:0]   act_q;
    logic [CNT_W-1:0]   acc;
    logic [BW-1:0]      beat;
    logic [IDX_W-1:0]   row;
    logic [CHUNK-1:0]   act_chunk;
    logic [CW-1:0]      cnt;
    logic [CNT_W-1:0]   sum;
    logic               fire;
    logic               last_beat;
    logic               last_row;
    logic               start_ok;
    logic               act_bit;

    assign busy      = (state == RUN);
    assign w_ready   = busy;
    assign fire      = w_valid & w_ready;
    assign start_ok  = start & (state == IDLE);
    assign last_beat = (beat == BW'(BEATS - 1));
    assign last_row  = (row == IDX_W'(NEURONS - 1));
    assign act_chunk = act_q[int'(beat) * CHUNK +: CHUNK];
    assign sum       = acc + CNT_W'(cnt);

    xnor_popcount_chunk #(
        .CHUNK(CHUNK)
    ) u_chunk (
        .w  (w_data),
        .a  (act_chunk),
        .cnt(cnt)
    );

`ifdef XNOR_BIAS_EN
    logic [CNT_W-1:0] thr_q;
    logic [CNT_W-1:0] thr_cur;

    // A single-beat row must see the live threshold, not the stale one.
    assign thr_cur = (beat == '0) ? thr_in : thr_q;
    assign act_bit = (sum >= thr_cur);

    // Capture the row threshold on its first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_q <= '0;
        end else if (fire && beat == '0) begin
            thr_q <= thr_in;
        end
    end
`else
    logic [CNT_W:0] sum2;

    assign sum2    = {sum, 1'b0};
    assign act_bit = (sum2 >= (CNT_W + 1)'(WIDTH));
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next state: leave RUN on the last beat of the last row.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (fire && last_beat && last_row) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath: act latch, accumulator, counters and outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_q     <= '0;
            acc       <= '0;
            beat      <= '0;
            row       <= '0;
            result    <= '0;
            bit_valid <= 1'b0;
            bit_out   <= 1'b0;
            bit_idx   <= '0;
            done      <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            done      <= 1'b0;
            if (start_ok) begin
                act_q  <= act_in;
                acc    <= '0;
                beat   <= '0;
                row    <= '0;
                result <= '0;
            end else if (fire) begin
                if (last_beat) begin
                    acc         <= '0;
                    beat        <= '0;
                    row         <= last_row ? '0 : row + IDX_W'(1);
                    bit_valid   <= 1'b1;
                    bit_out     <= act_bit;
                    bit_idx     <= row;
                    result[row] <= act_bit;
                    done        <= last_row;
                end else begin
                    acc  <= sum;
                    beat <= beat + BW'(1);
                end
            end
        end
    end

endmodule
